// File: rtl/brick_pkg.sv
// Shared playfield geometry, FSM state type and row popcount helper.
// Brick index is row*COLS + col.
package brick_pkg;

  localparam int COLS = 20;
  localparam int ROWS = 15;
  localparam int N    = COLS * ROWS;
  localparam int IDXW = 9;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [4:0] popcount20(input logic [19:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 20; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/brick_row_rom.sv
// Combinational brick pattern per (level, row); level 3 falls through to the level-2 pattern.
// Zero latency, no flow control.
module brick_row_rom
  import brick_pkg::*;
(
  input  logic [1:0]      i_level,
  input  logic [3:0]      i_row,
  output logic [COLS-1:0] o_pattern
);

  always_comb begin
    o_pattern = '0;
    case (i_level)
      2'd0: begin
        if (i_row < 4'd5) o_pattern = '1;
      end
      2'd1: begin
        // checkerboard: bit c set when (row+col) is even
        if (i_row < 4'd10) o_pattern = i_row[0] ? 20'hAAAAA : 20'h55555;
      end
      default: begin
        if (i_row < 4'd15) o_pattern = 20'h7FFFE;
      end
    endcase
  end

endmodule

// File: rtl/brick_field_ctrl.sv
// Playfield brick state: loads a level pattern one row per cycle, then clears bricks on hit requests.
// Hit result is reported one cycle after acceptance; oHit_ready is low while loading or a reload is pending.
module brick_field_ctrl
  import brick_pkg::*;
(
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [1:0]      iLevel,
  input  logic            iLevel_RST,
  input  logic            iHit_valid,
  input  logic [IDXW-1:0] iHit_index,
  output logic            oHit_ready,
  output logic            oHit_done,
  output logic            oHit_result,
  output logic [N-1:0]    oState_flag,
  output logic [8:0]      oBricks_left,
  output logic            oLoading,
  output logic            oCleared
);

  state_t          r_state;
  logic [3:0]      r_row;
  logic [N-1:0]    r_flags;
  logic [8:0]      r_left;
  logic            r_done;
  logic            r_result;
  logic [1:0]      r_level_q;
  logic [1:0]      r_level_lat;
  logic            r_lrst_q;

  logic [1:0]      w_level_eff;
  logic            w_load_req;
  logic            w_accept;
  logic            w_hit_set;
  logic [COLS-1:0] w_row_pat;
  logic [511:0]    w_flags_pad;
  logic [N-1:0]    w_one;
  logic [N-1:0]    w_clr_mask;

  assign w_level_eff = (iLevel == 2'd3) ? 2'd2 : iLevel;
  assign w_load_req  = (r_lrst_q && !iLevel_RST) || (w_level_eff != r_level_q);
  assign oHit_ready  = (r_state == S_RUN) && !w_load_req;
  assign w_accept    = iHit_valid && oHit_ready;

  // pad to the full index range so out-of-range indices read as empty
  assign w_flags_pad = {{(512 - N){1'b0}}, r_flags};
  assign w_hit_set   = w_flags_pad[iHit_index];
  assign w_one       = {{(N - 1){1'b0}}, 1'b1};
  assign w_clr_mask  = w_one << iHit_index;

  brick_row_rom u_rom (
    .i_level   (r_level_lat),
    .i_row     (r_row),
    .o_pattern (w_row_pat)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= S_LOAD;
      r_row       <= '0;
      r_flags     <= '0;
      r_left      <= '0;
      r_done      <= 1'b0;
      r_result    <= 1'b0;
      r_level_q   <= w_level_eff;
      r_level_lat <= w_level_eff;
      r_lrst_q    <= iLevel_RST;
    end else begin
      r_level_q <= w_level_eff;
      r_lrst_q  <= iLevel_RST;
      r_done    <= w_accept;
      r_result  <= w_accept && w_hit_set;
      if (w_load_req) begin
        r_state     <= S_LOAD;
        r_row       <= '0;
        r_flags     <= '0;
        r_left      <= '0;
        r_level_lat <= w_level_eff;
      end else if (r_state == S_LOAD) begin
        r_flags[r_row*COLS +: COLS] <= w_row_pat;
        r_left <= r_left + {4'd0, popcount20(w_row_pat)};
        if (r_row == 4'(ROWS - 1)) begin
          r_state <= S_RUN;
        end else begin
          r_row <= r_row + 4'd1;
        end
      end else if (w_accept && w_hit_set && (r_left != 9'd0)) begin
        r_flags <= r_flags & ~w_clr_mask;
        r_left  <= r_left - 9'd1;
      end
    end
  end

  assign oHit_done    = r_done;
  assign oHit_result  = r_result;
  assign oState_flag  = r_flags;
  assign oBricks_left = r_left;
  assign oLoading     = (r_state == S_LOAD);
  assign oCleared     = (r_state == S_RUN) && (r_left == 9'd0);

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Directed bench for brick_field_ctrl: load timing, hits, level changes, restarts and reset.
module tb_brick_field_ctrl;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic [1:0]   iLevel;
  logic         iLevel_RST;
  logic         iHit_valid;
  logic [8:0]   iHit_index;
  logic         oHit_ready;
  logic         oHit_done;
  logic         oHit_result;
  logic [299:0] oState_flag;
  logic [8:0]   oBricks_left;
  logic         oLoading;
  logic         oCleared;

  int n_cmp = 0;
  int n_bad = 0;
  logic [299:0] model;

  brick_field_ctrl dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iLevel       (iLevel),
    .iLevel_RST   (iLevel_RST),
    .iHit_valid   (iHit_valid),
    .iHit_index   (iHit_index),
    .oHit_ready   (oHit_ready),
    .oHit_done    (oHit_done),
    .oHit_result  (oHit_result),
    .oState_flag  (oState_flag),
    .oBricks_left (oBricks_left),
    .oLoading     (oLoading),
    .oCleared     (oCleared)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [299:0] act, input logic [299:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [299:0] pat(input int lvl);
    logic [299:0] f;
    f = '0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        case (lvl)
          0:       f[r*20+c] = (r < 5);
          1:       f[r*20+c] = (r < 10) && (((r + c) % 2) == 0);
          default: f[r*20+c] = (c >= 1) && (c <= 18);
        endcase
      end
    end
    return f;
  endfunction

  // counts cycles with oLoading high from the current sample, bounded
  task automatic wait_load(output int n);
    n = 0;
    while (oLoading && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic do_hit(input int idx, input logic exp_res, input string tag);
    iHit_valid = 1'b1;
    iHit_index = 9'(idx);
    tick();
    iHit_valid = 1'b0;
    chk({tag, "_done"}, 300'(oHit_done), 300'(1));
    chk({tag, "_res"}, 300'(oHit_result), 300'(exp_res));
    if (exp_res && idx < 300) model[idx] = 1'b0;
  endtask

  initial begin
    int n;
    int nd;
    int nr;
    iRST = 1'b1; iLevel = 2'd0; iLevel_RST = 1'b1;
    iHit_valid = 1'b0; iHit_index = '0;
    repeat (3) tick();
    chk("rst_flags", oState_flag, '0);
    chk("rst_left", 300'(oBricks_left), 300'(0));
    chk("rst_done", 300'(oHit_done), 300'(0));
    chk("rst_cleared", 300'(oCleared), 300'(0));
    iRST = 1'b0;

    // 1. initial load of level 0
    wait_load(n);
    chk("load0_len", 300'(n), 300'(15));
    model = pat(0);
    chk("load0_flags", oState_flag, model);
    chk("load0_left", 300'(oBricks_left), 300'(100));
    chk("run_ready", 300'(oHit_ready), 300'(1));

    // 2. single hits
    do_hit(5, 1'b1, "hit5");
    chk("hit5_flag", 300'(oState_flag[5]), 300'(0));
    chk("hit5_left", 300'(oBricks_left), 300'(99));
    do_hit(5, 1'b0, "hit5b");
    chk("hit5b_left", 300'(oBricks_left), 300'(99));

    // 3. out of range and empty slot
    do_hit(300, 1'b0, "hit300");
    do_hit(150, 1'b0, "hit150");
    chk("hit_miss_flags", oState_flag, model);

    // 4. clear all L0 bricks back-to-back
    nd = 0; nr = 0;
    iHit_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      iHit_index = 9'(i);
      tick();
      if (oHit_done) nd++;
      if (oHit_result) nr++;
    end
    iHit_valid = 1'b0;
    chk("b2b_done", 300'(nd), 300'(100));
    chk("b2b_res", 300'(nr), 300'(99));
    chk("b2b_flags", oState_flag, '0);
    chk("b2b_left", 300'(oBricks_left), 300'(0));
    chk("b2b_cleared", 300'(oCleared), 300'(1));

    // 5. level change mid-load restarts from row 0
    iLevel = 2'd1;
    tick();
    chk("l1_loading", 300'(oLoading), 300'(1));
    chk("l1_cleared", 300'(oCleared), 300'(0));
    repeat (6) tick();
    iLevel = 2'd2;
    chk("l1_ready_lo", 300'(oHit_ready), 300'(0));
    tick();
    chk("restart_left", 300'(oBricks_left), 300'(0));
    wait_load(n);
    chk("l2_len", 300'(n), 300'(15));
    chk("l2_left", 300'(oBricks_left), 300'(270));
    chk("l2_f0", 300'(oState_flag[0]), 300'(0));
    chk("l2_f1", 300'(oState_flag[1]), 300'(1));
    chk("l2_flags", oState_flag, pat(2));

    // 6. iLevel_RST pulse reloads the same level
    iLevel = 2'd0;
    tick();
    wait_load(n);
    chk("l0b_left", 300'(oBricks_left), 300'(100));
    iHit_valid = 1'b1;
    for (int i = 0; i < 58; i++) begin
      iHit_index = 9'(i);
      tick();
    end
    iHit_valid = 1'b0;
    tick();
    chk("left42", 300'(oBricks_left), 300'(42));
    iLevel_RST = 1'b0;
    tick();
    iLevel_RST = 1'b1;
    chk("lrst_loading", 300'(oLoading), 300'(1));
    chk("lrst_left0", 300'(oBricks_left), 300'(0));
    wait_load(n);
    chk("lrst_len", 300'(n), 300'(15));
    chk("lrst_left", 300'(oBricks_left), 300'(100));
    chk("lrst_flags", oState_flag, pat(0));

    // reset mid-RUN with a hit presented in the same cycle
    iHit_valid = 1'b1; iHit_index = 9'd3; iRST = 1'b1;
    tick();
    iHit_valid = 1'b0; iRST = 1'b0;
    chk("mrst_flags", oState_flag, '0);
    chk("mrst_left", 300'(oBricks_left), 300'(0));
    chk("mrst_done", 300'(oHit_done), 300'(0));
    wait_load(n);
    chk("mrst_len", 300'(n), 300'(15));
    chk("mrst_reload", 300'(oBricks_left), 300'(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
